// File: rtl/cache_pkg.sv
// Shared types and constants for the cache set miss sequencer.
// Provides the FSM state enum, control-bus bit positions and control encodings.
// Default geometry macros CACHE_T / CACHE_B are supplied here when the build does not set them.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_pkg;

    typedef enum logic [1:0] {
        ST_COMPARE       = 2'd0,
        ST_WRITE_BACK    = 2'd1,
        ST_ALLOCATE      = 2'd2,
        ST_WRITE_THROUGH = 2'd3
    } cache_state_e;

    // Control bus layout: {write_en, set_valid, set_dirty, strategy_en, offset_sel}
    localparam int CTRL_WIDTH       = 5;
    localparam int CTRL_WRITE_EN    = 4;
    localparam int CTRL_SET_VALID   = 3;
    localparam int CTRL_SET_DIRTY   = 2;
    localparam int CTRL_STRATEGY_EN = 1;
    localparam int CTRL_OFFSET_SEL  = 0;

    // Idle: processor offset selected, nothing written
    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE      = 5'b00001;
    // Write hit: write processor data, mark valid and dirty, update replacement
    localparam logic [CTRL_WIDTH-1:0] CTRL_WRITE_HIT = 5'b11111;
    // Refill word: write memory data at memory offset, mark valid and clean
    localparam logic [CTRL_WIDTH-1:0] CTRL_REFILL    = 5'b11000;

endpackage

// File: rtl/cache_sequencer_burst_counter.sv
// Word counter for memory bursts: clears, increments, flags the final word.
// Counter updates one cycle after inc_i/clr_i; last_o is combinational from the count.
// Wraps to zero after the all-ones value, so a full line burst returns it to zero.
module burst_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority, natural wrap at 2^WIDTH words
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, reset aborts any burst in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

endmodule

// File: rtl/cache_sequencer.sv
// Miss-handling sequencer for one cache set: hits, dirty write-back, word-wise refill.
// Hits complete in the request cycle; misses take W (clean) or 2W (dirty) memory handshakes plus one re-compare.
// Processor is stalled via ready_o; bursts hold address/strobe until mem_ready_i. Option: CACHE_WRITE_ALLOCATE_EN.
module cache_sequencer
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic [4:0]           control_o,
    output logic                 ready_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o
);

    localparam int CNT_W = OFFSET_WIDTH - 2;

    cache_state_e state_q;
    cache_state_e state_d;

    logic             req;
    logic             is_write;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [31:0]      wb_addr;
    logic [31:0]      alloc_addr;
    logic             unused_addr_lsb;

    // A simultaneous read and write is serviced as a write
    assign req      = read_i | write_i;
    assign is_write = write_i;

    // Victim line lives at the old tag with the current index; refill fetches the requested line
    assign wb_addr    = {tag_i, addr_i[31-TAG_WIDTH:OFFSET_WIDTH], cnt, 2'b00};
    assign alloc_addr = {addr_i[31:OFFSET_WIDTH], cnt, 2'b00};

    assign unused_addr_lsb = ^addr_i[1:0];

`ifndef CACHE_WRITE_ALLOCATE_EN
    logic [31:0] wt_addr;
    assign wt_addr = {addr_i[31:2], 2'b00};
`endif

    burst_counter #(
        .WIDTH (CNT_W)
    ) u_burst_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoded outputs; reset forces the idle output set immediately
    always_comb begin
        state_d     = state_q;
        control_o   = CTRL_IDLE;
        ready_o     = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            ST_COMPARE: begin
                // Counter is idle here; stray mem_ready_i pulses must not advance it
                cnt_clr = 1'b1;
                if (req) begin
                    if (hit_i) begin
                        ready_o = 1'b1;
                        if (is_write) begin
                            control_o = CTRL_WRITE_HIT;
                        end else begin
                            control_o[CTRL_STRATEGY_EN] = 1'b1;
                        end
                    end else begin
                        control_o[CTRL_STRATEGY_EN] = 1'b1;
`ifdef CACHE_WRITE_ALLOCATE_EN
                        if (dirty_i) begin
                            state_d = ST_WRITE_BACK;
                        end else begin
                            state_d = ST_ALLOCATE;
                        end
`else
                        if (is_write) begin
                            state_d = ST_WRITE_THROUGH;
                        end else if (dirty_i) begin
                            state_d = ST_WRITE_BACK;
                        end else begin
                            state_d = ST_ALLOCATE;
                        end
`endif
                    end
                end
            end

            ST_WRITE_BACK: begin
                control_o   = '0;
                mem_write_o = 1'b1;
                mem_addr_o  = wb_addr;
                if (mem_ready_i) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_ALLOCATE;
                    end
                end
            end

            ST_ALLOCATE: begin
                control_o  = '0;
                mem_read_o = 1'b1;
                mem_addr_o = alloc_addr;
                if (mem_ready_i) begin
                    control_o = CTRL_REFILL;
                    cnt_inc   = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_COMPARE;
                    end
                end
            end

`ifndef CACHE_WRITE_ALLOCATE_EN
            ST_WRITE_THROUGH: begin
                mem_write_o = 1'b1;
                mem_addr_o  = wt_addr;
                if (mem_ready_i) begin
                    ready_o = 1'b1;
                    state_d = ST_COMPARE;
                end
            end
`endif

            default: begin
                state_d = ST_COMPARE;
            end
        endcase

        if (rst_i) begin
            control_o   = CTRL_IDLE;
            ready_o     = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            mem_addr_o  = '0;
        end
    end

endmodule

// File: tb/tb_cache_sequencer.sv
// Self-checking bench for cache_sequencer with W=4 words per line.
// A one-line set model drives hit/dirty/tag; expected memory ops come from the line state.
// Directed test-plan cases followed by randomized requests and memory wait patterns.
module tb_cache_sequencer;

    localparam int TW = 20;
    localparam int OW = 4;
    localparam int W  = 4;
    localparam int BUDGET = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        hit_i = 1'b0;
    logic        dirty_i = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic        mem_ready_i = 1'b0;
    logic [4:0]  control_o;
    logic        ready_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;

    always #5 clk_i = ~clk_i;

    cache_sequencer #(
        .TAG_WIDTH    (TW),
        .OFFSET_WIDTH (OW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .read_i      (read_i),
        .write_i     (write_i),
        .addr_i      (addr_i),
        .hit_i       (hit_i),
        .dirty_i     (dirty_i),
        .tag_i       (tag_i),
        .mem_ready_i (mem_ready_i),
        .control_o   (control_o),
        .ready_o     (ready_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o)
    );

    int errors = 0;
    int checks = 0;

    // kind: 0 refill read, 1 write-back write, 2 write-through write
    typedef struct {
        int          kind;
        logic [31:0] addr;
    } op_t;

    op_t ops_q[$];

    logic          ln_valid = 1'b0;
    logic          ln_dirty = 1'b0;
    logic [TW-1:0] ln_tag   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_set(input logic [31:0] a);
        hit_i   = ln_valid && (ln_tag == a[31:12]);
        dirty_i = ln_valid && ln_dirty;
        tag_i   = ln_tag;
    endtask

    task automatic push_op(input int kind, input logic [31:0] addr);
        op_t o;
        o.kind = kind;
        o.addr = addr;
        ops_q.push_back(o);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, ready_o, 0);
        check({tag, "_ctrl"}, control_o, 5'b00001);
        check({tag, "_mrd"}, mem_read_o, 0);
        check({tag, "_mwr"}, mem_write_o, 0);
        check({tag, "_maddr"}, mem_addr_o, 0);
    endtask

    // Called just after a rising edge; returns just after a rising edge with the request dropped.
    // mode: 0 memory always ready, 1 ready every other cycle, 2 random
    task automatic run_req(input bit rd, input bit wr, input logic [31:0] a, input int mode);
        bit          hit;
        bit          wt;
        bit          done;
        int          exp_lat;
        logic [4:0]  exp_ctrl;
        logic [31:0] base;
        bit          prev_wait;
        logic        prev_rd;
        logic        prev_wr;
        logic [31:0] prev_addr;
        op_t         o;

        hit  = ln_valid && (ln_tag == a[31:12]);
        wt   = 1'b0;
        done = 1'b0;
        prev_wait = 1'b0;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        prev_addr = '0;
        ops_q.delete();
        if (!hit) begin
`ifndef CACHE_WRITE_ALLOCATE_EN
            if (wr) begin
                wt = 1'b1;
                push_op(2, {a[31:2], 2'b00});
            end else
`endif
            begin
                if (ln_valid && ln_dirty) begin
                    base = {ln_tag, a[11:4], 4'h0};
                    for (int i = 0; i < W; i++) push_op(1, base + 32'(4 * i));
                end
                base = {a[31:4], 4'h0};
                for (int i = 0; i < W; i++) push_op(0, base + 32'(4 * i));
            end
        end
        exp_ctrl = wt ? 5'b00001 : (wr ? 5'b11111 : 5'b00011);
        exp_lat  = wt ? 1 : (hit ? 0 : ops_q.size() + 1);

        read_i  = rd;
        write_i = wr;
        addr_i  = a;
        drive_set(a);

        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            if (mode == 0) mem_ready_i = 1'b1;
            else if (mode == 1) mem_ready_i = (cyc % 2 == 1);
            else mem_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check("strobe_excl", mem_read_o & mem_write_o, 0);
            if (prev_wait) begin
                check("hold_rd", mem_read_o, prev_rd);
                check("hold_wr", mem_write_o, prev_wr);
                check("hold_addr", mem_addr_o, prev_addr);
            end
            if (mem_read_o || mem_write_o) begin
                check("op_pending", ops_q.size() != 0, 1);
                if (ops_q.size() != 0) begin
                    o = ops_q[0];
                    check("op_is_read", mem_read_o, o.kind == 0);
                    check("op_addr", mem_addr_o, o.addr);
                    check("burst_ctrl", control_o,
                          (o.kind == 2) ? 5'b00001 :
                          ((o.kind == 0 && mem_ready_i) ? 5'b11000 : 5'b00000));
                    if (mem_ready_i) begin
                        void'(ops_q.pop_front());
                        if (o.kind == 0 && ops_q.size() == 0) begin
                            ln_valid = 1'b1;
                            ln_dirty = 1'b0;
                            ln_tag   = a[31:12];
                            drive_set(a);
                        end
                    end
                end
            end
            prev_wait = (mem_read_o || mem_write_o) && !mem_ready_i;
            prev_rd   = mem_read_o;
            prev_wr   = mem_write_o;
            prev_addr = mem_addr_o;
            if (ready_o) begin
                done = 1'b1;
                check("ops_done", ops_q.size(), 0);
                check("ready_ctrl", control_o, exp_ctrl);
                if (mode == 0) check("latency", cyc, exp_lat);
                if (wr && !wt) ln_dirty = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) check("timeout_ready", ready_o, 1);

        read_i      = 1'b0;
        write_i     = 1'b0;
        mem_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        check_idle("post_req");
        @(posedge clk_i);
        #1;
    endtask

    // A request must stay asserted for as long as the sequencer is running a burst for it
    always @(negedge clk_i) begin
        if (!rst_i && (mem_read_o || mem_write_o)) begin
            assert (read_i || write_i) else $error("request dropped during memory burst");
        end
    end

    initial begin
        logic [31:0] a;
        int          k;

        #1;
        check_idle("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check_idle("idle_memrdy");
        @(posedge clk_i);
        #1;

        // Read hit
        ln_valid = 1'b1; ln_dirty = 1'b0; ln_tag = 20'h00001;
        run_req(1'b1, 1'b0, 32'h0000_1004, 0);

        // Clean read miss, memory always ready
        run_req(1'b1, 1'b0, 32'h0000_2008, 0);

        // Dirty miss with victim at 0x3000, memory ready every other cycle
        ln_valid = 1'b1; ln_dirty = 1'b1; ln_tag = 20'h00003;
        run_req(1'b1, 1'b0, 32'h0000_5000, 1);

        // Write hit
        run_req(1'b0, 1'b1, 32'h0000_5004, 0);

        // Write miss against a dirty line
        run_req(1'b0, 1'b1, 32'h0000_7008, 0);

        // Reset during the second refill word
        ln_valid = 1'b1; ln_dirty = 1'b0; ln_tag = 20'h00001;
        read_i = 1'b1; addr_i = 32'h0000_9000; drive_set(32'h0000_9000);
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_pre_word0", mem_addr_o, 32'h0000_9000);
        @(posedge clk_i);
        #1;
        check("rst_pre_word1", mem_addr_o, 32'h0000_9004);
        rst_i = 1'b1;
        #1;
        check_idle("rst_mid");
        @(posedge clk_i);
        #1;
        read_i = 1'b0;
        rst_i  = 1'b0;
        @(posedge clk_i);
        #1;
        run_req(1'b1, 1'b0, 32'h0000_9000, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            a = {20'($urandom_range(1, 4)), 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            k = $urandom_range(0, 2);
            run_req(k != 1, k != 0, a, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
